// File: rtl/router_pkg.sv
// Shared types and constants for the pixel stream router.
package router_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2
  } router_state_t;

  localparam int unsigned STAT_W = 16;

endpackage : router_pkg

// File: rtl/px_sync_fifo.sv
// Synchronous output FIFO with registered valid/full flags and an overflow pulse.
// A push into a full FIFO with no simultaneous pop is discarded.
module px_sync_fifo #(
  parameter int unsigned PX_W  = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            push_i,
  input  logic [PX_W-1:0] data_i,
  input  logic            pop_i,
  output logic [PX_W-1:0] data_o,
  output logic            valid_o,
  output logic            full_o,
  output logic            ovf_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [PX_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic            valid_q;
  logic            full_q;
  logic            ovf_q;
  logic            do_push;
  logic            do_pop;

  // Qualify push/pop and compute the next occupancy.
  always_comb begin
    do_pop  = pop_i && valid_q;
    do_push = push_i && (!full_q || do_pop);
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointers, occupancy, flags and overflow pulse.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      valid_q <= (count_d != '0);
      full_q  <= (count_d == CW'(DEPTH));
      ovf_q   <= push_i && full_q && !do_pop;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = valid_q;
  assign full_o  = full_q;
  assign ovf_o   = ovf_q;

endmodule : px_sync_fifo

// File: rtl/px_stream_router.sv
// Routes SPI pixels to one selected engine channel and collects that channel's
// results into an output FIFO. Mode changes wait until in-flight pixels return.
// Optional statistics (drop counter, sticky overflow) enabled by ROUTER_STATS_EN.
module px_stream_router
  import router_pkg::*;
#(
  parameter int unsigned PX_W       = 24,
  parameter int unsigned N_CH       = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned INFL_W     = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [$clog2(N_CH)-1:0]  mode_req_i,
  output logic [$clog2(N_CH)-1:0]  mode_o,
  output logic                     busy_o,
  input  logic [PX_W-1:0]          in_px_i,
  input  logic                     in_rdy_i,
  output logic [PX_W-1:0]          ch_px_o,
  output logic [N_CH-1:0]          ch_rdy_o,
  input  logic [N_CH*PX_W-1:0]     ch_px_i,
  input  logic [N_CH-1:0]          ch_rdy_i,
  output logic [PX_W-1:0]          out_px_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [STAT_W-1:0]        drop_cnt_o,
  output logic                     ovf_o
);

  localparam int unsigned MODE_W = $clog2(N_CH);
  localparam logic [INFL_W-1:0] INFL_MAX = '1;

  router_state_t     state_q;
  logic [MODE_W-1:0] mode_q;
  logic              busy_q;
  logic [INFL_W-1:0] infl_q;
  logic [INFL_W-1:0] infl_d;
  logic [PX_W-1:0]   ch_px_q;
  logic [N_CH-1:0]   ch_rdy_q;

  logic              req_ok;
  logic              accept;
  logic              drop;
  logic              res_rdy;
  logic [PX_W-1:0]   res_px;
  logic              fifo_full;
  logic              fifo_ovf;

  // Input acceptance, result selection and in-flight bookkeeping.
  always_comb begin
    req_ok  = (int'(mode_req_i) < int'(N_CH));
    res_rdy = ch_rdy_i[mode_q];
    res_px  = ch_px_i[int'(mode_q)*int'(PX_W) +: PX_W];
    accept  = (state_q == RUN) && in_rdy_i && (infl_q != INFL_MAX);
    drop    = in_rdy_i && !accept;
    infl_d  = infl_q;
    if (accept && !res_rdy) begin
      infl_d = infl_q + INFL_W'(1);
    end else if (!accept && res_rdy && (infl_q != '0)) begin
      infl_d = infl_q - INFL_W'(1);
    end
  end

  // Mode FSM plus registered channel-side outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= RUN;
      mode_q   <= '0;
      busy_q   <= 1'b0;
      infl_q   <= '0;
      ch_px_q  <= '0;
      ch_rdy_q <= '0;
    end else begin
      infl_q   <= infl_d;
      ch_rdy_q <= '0;
      if (accept) begin
        ch_px_q  <= in_px_i;
        ch_rdy_q <= N_CH'(1) << mode_q;
      end
      case (state_q)
        RUN: begin
          if (req_ok && (mode_req_i != mode_q)) begin
            state_q <= DRAIN;
            busy_q  <= 1'b1;
          end
        end
        DRAIN: begin
          if (infl_q == '0) state_q <= SWITCH;
        end
        SWITCH: begin
          if (req_ok) mode_q <= mode_req_i;
          state_q <= RUN;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= RUN;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  px_sync_fifo #(
    .PX_W  (PX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (res_rdy),
    .data_i  (res_px),
    .pop_i   (out_ready_i),
    .data_o  (out_px_o),
    .valid_o (out_valid_o),
    .full_o  (fifo_full),
    .ovf_o   (fifo_ovf)
  );

`ifdef ROUTER_STATS_EN
  logic [STAT_W-1:0] drop_cnt_q;
  logic              ovf_q;
  logic              unused_sig;

  // Saturating drop counter and sticky overflow flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + STAT_W'(1);
      if (fifo_ovf) ovf_q <= 1'b1;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
  assign ovf_o      = ovf_q;
  assign unused_sig = fifo_full;
`else
  logic unused_sig;

  assign drop_cnt_o = '0;
  assign ovf_o      = 1'b0;
  assign unused_sig = ^{fifo_full, fifo_ovf, drop};
`endif

  assign mode_o   = mode_q;
  assign busy_o   = busy_q;
  assign ch_px_o  = ch_px_q;
  assign ch_rdy_o = ch_rdy_q;

endmodule : px_stream_router

// File: tb/tb_px_stream_router.sv
// Scoreboard bench for px_stream_router: stimulus queues expected channel
// issues and FIFO words; a negedge monitor pops and compares them.
module tb_px_stream_router;

  localparam int unsigned PX_W   = 24;
  localparam int unsigned N_CH   = 4;
  localparam int unsigned FD     = 4;
  localparam int unsigned INFL_W = 4;
`ifdef ROUTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset_i = 1'b1;
  logic [1:0]          mode_req_i = '0;
  logic [1:0]          mode_o;
  logic                busy_o;
  logic [PX_W-1:0]     in_px_i = '0;
  logic                in_rdy_i = 1'b0;
  logic [PX_W-1:0]     ch_px_o;
  logic [N_CH-1:0]     ch_rdy_o;
  logic [N_CH*PX_W-1:0] ch_px_i = '0;
  logic [N_CH-1:0]     ch_rdy_i = '0;
  logic [PX_W-1:0]     out_px_o;
  logic                out_valid_o;
  logic                out_ready_i = 1'b0;
  logic [15:0]         drop_cnt_o;
  logic                ovf_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [N_CH-1:0] rdy;
    logic [PX_W-1:0] px;
  } ch_ev_t;

  ch_ev_t          exp_ch[$];
  logic [PX_W-1:0] exp_out[$];
  ch_ev_t          mon_ev;
  logic [PX_W-1:0] mon_word;

  always #5 clk = ~clk;

  px_stream_router #(
    .PX_W       (PX_W),
    .N_CH       (N_CH),
    .FIFO_DEPTH (FD),
    .INFL_W     (INFL_W)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .mode_req_i  (mode_req_i),
    .mode_o      (mode_o),
    .busy_o      (busy_o),
    .in_px_i     (in_px_i),
    .in_rdy_i    (in_rdy_i),
    .ch_px_o     (ch_px_o),
    .ch_rdy_o    (ch_rdy_o),
    .ch_px_i     (ch_px_i),
    .ch_rdy_i    (ch_rdy_i),
    .out_px_o    (out_px_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .drop_cnt_o  (drop_cnt_o),
    .ovf_o       (ovf_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every channel issue and every FIFO pop against the queues.
  always @(negedge clk) begin
    if (!reset_i) begin
      if (ch_rdy_o != '0) begin
        if (exp_ch.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ch_issue: unexpected ch_rdy_o=%b px=0x%0h expected none", ch_rdy_o, ch_px_o);
        end else begin
          mon_ev = exp_ch.pop_front();
          check("ch_rdy_o", 32'(ch_rdy_o), 32'(mon_ev.rdy));
          check("ch_px_o", 32'(ch_px_o), 32'(mon_ev.px));
        end
      end
      if (out_valid_o && out_ready_i) begin
        if (exp_out.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_pop: unexpected word 0x%0h expected none", out_px_o);
        end else begin
          mon_word = exp_out.pop_front();
          check("out_px_o", 32'(out_px_o), 32'(mon_word));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_px(input logic [PX_W-1:0] px, input logic [N_CH-1:0] rdy, input bit expect_issue);
    in_px_i  = px;
    in_rdy_i = 1'b1;
    if (expect_issue) exp_ch.push_back('{rdy: rdy, px: px});
    tick();
    in_rdy_i = 1'b0;
  endtask

  task automatic ret(input int ch, input logic [PX_W-1:0] val, input bit expect_word);
    ch_px_i = '0;
    ch_px_i[ch*PX_W +: PX_W] = val;
    ch_rdy_i = '0;
    ch_rdy_i[ch] = 1'b1;
    if (expect_word) exp_out.push_back(val);
    tick();
    ch_rdy_i = '0;
  endtask

  task automatic drain_out();
    out_ready_i = 1'b1;
    for (int i = 0; i < 12 && out_valid_o; i++) tick();
    check("drain_valid", 32'(out_valid_o), 32'd0);
    check("drain_queue", 32'(exp_out.size()), 32'd0);
  endtask

  initial begin
    // Reset state.
    tick();
    tick();
    check("rst_mode", 32'(mode_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_valid", 32'(out_valid_o), 32'd0);
    check("rst_ch_rdy", 32'(ch_rdy_o), 32'd0);
    check("rst_ch_px", 32'(ch_px_o), 32'd0);
    check("rst_drop", 32'(drop_cnt_o), 32'd0);
    check("rst_ovf", 32'(ovf_o), 32'd0);
    reset_i = 1'b0;
    tick();

    // Forwarding to channel 0.
    send_px(24'h123456, 4'b0001, 1'b1);
    send_px(24'hABCDEF, 4'b0001, 1'b1);
    send_px(24'h000001, 4'b0001, 1'b1);
    tick();

    // Results collected in order.
    ret(0, 24'h000011, 1'b1);
    ret(0, 24'h000022, 1'b1);
    ret(0, 24'h000033, 1'b1);
    check("fifo_valid3", 32'(out_valid_o), 32'd1);
    check("fifo_head", 32'(out_px_o), 32'h11);
    drain_out();

    // Mode switch with drain.
    send_px(24'hAAAA01, 4'b0001, 1'b1);
    send_px(24'hAAAA02, 4'b0001, 1'b1);
    mode_req_i = 2'd2;
    tick();
    check("drain_busy", 32'(busy_o), 32'd1);
    check("drain_mode", 32'(mode_o), 32'd0);
    send_px(24'hDEAD00, 4'b0000, 1'b0);
    tick();
    check("drain_drop", 32'(drop_cnt_o), STATS ? 32'd1 : 32'd0);
    ret(0, 24'h000055, 1'b1);
    ret(0, 24'h000066, 1'b1);
    check("drain_wait_busy", 32'(busy_o), 32'd1);
    tick();
    check("switch_busy", 32'(busy_o), 32'd1);
    tick();
    check("run_busy", 32'(busy_o), 32'd0);
    check("run_mode", 32'(mode_o), 32'd2);
    send_px(24'h0F0F0F, 4'b0100, 1'b1);
    ret(2, 24'h000077, 1'b1);
    tick();
    tick();

    // Non-selected channels are ignored.
    ret(1, 24'h000099, 1'b0);
    ret(0, 24'h000098, 1'b0);
    tick();
    check("ignore_valid", 32'(out_valid_o), 32'd0);
    check("ignore_queue", 32'(exp_out.size()), 32'd0);

    // Overflow: five pushes into a depth-4 FIFO.
    out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) ret(2, PX_W'(32'h100 + i), (i < 4));
    tick();
    tick();
    check("ovf_valid", 32'(out_valid_o), 32'd1);
    check("ovf_flag", 32'(ovf_o), STATS ? 32'd1 : 32'd0);
    // Push and pop together while full: both happen.
    out_ready_i = 1'b1;
    ret(2, 24'h000200, 1'b1);
    out_ready_i = 1'b0;
    check("pushpop_valid", 32'(out_valid_o), 32'd1);
    drain_out();

    // Reset in DRAIN with two words queued.
    out_ready_i = 1'b0;
    ret(2, 24'h000301, 1'b0);
    ret(2, 24'h000302, 1'b0);
    send_px(24'h123000, 4'b0100, 1'b1);
    mode_req_i = 2'd0;
    tick();
    check("rd_busy", 32'(busy_o), 32'd1);
    send_px(24'h444444, 4'b0000, 1'b0);
    check("rd_drop", 32'(drop_cnt_o), STATS ? 32'd2 : 32'd0);
    check("rd_valid", 32'(out_valid_o), 32'd1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("post_rst_busy", 32'(busy_o), 32'd0);
    check("post_rst_mode", 32'(mode_o), 32'd0);
    check("post_rst_valid", 32'(out_valid_o), 32'd0);
    check("post_rst_drop", 32'(drop_cnt_o), 32'd0);
    check("post_rst_ovf", 32'(ovf_o), 32'd0);
    tick();
    check("post_rst_run", 32'(busy_o), 32'd0);

    check("final_ch_queue", 32'(exp_ch.size()), 32'd0);
    check("final_out_queue", 32'(exp_out.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_px_stream_router
